// File: rtl/tns_decoder_33.sv
// tns_decoder_33
//   Receive-side decoder for the 33-wire TNS crosstalk-avoidance bus.
//   Each accepted codeword is decoded by a weighted sum of its bits over a
//   three-stage pipeline. Two link monitors run alongside: a range check on the
//   decoded sum, and a 3C (opposite adjacent transition) check against the
//   previously accepted codeword. A saturating counter totals the flagged words.
//
//   Ports
//     clock       in   rising-edge clock
//     reset       in   asynchronous active-high reset
//     code_valid  in   codein is valid this cycle
//     codein      in   [32:0] received codeword
//     clr_count   in   synchronous clear of err_count (wins over an increment)
//     data_valid  out  dataout / range_err / xt_err valid, 3 cycles after input
//     dataout     out  [DLEN-1:0] decoded word (holds across bubbles)
//     range_err   out  decoded sum >= 2^DLEN
//     xt_err      out  3C violation versus the previous accepted codeword
//     err_count   out  [CNT_W-1:0] saturating count of flagged words
//
//   Weights: bit i carries Fibonacci number F(i+1) (1,1,2,3,5,...), so group g
//   has C = F(3g-2), B = F(3g-1), A = F(3g). codein[0] therefore weighs 1, and
//   TNS11_A = F(33) = 3524578. The matching encoder only emits words whose
//   adjacent pairs never use both 01 and 10, which is what makes it 3C-free.
module tns_decoder_33 #(
  parameter int DLEN  = 23,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [32:0]      codein,
  input  logic             clr_count,
  output logic             data_valid,
  output logic [DLEN-1:0]  dataout,
  output logic             range_err,
  output logic             xt_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int NW = 33;
  localparam int SW = DLEN + 2;
  localparam int NP = 4;

  typedef logic [SW-1:0] wtab_t [NW];

  function automatic wtab_t f_wtab();
    wtab_t       t;
    logic [SW-1:0] a, b, n;
    a = 1;
    b = 1;
    for (int i = 0; i < NW; i++) begin
      t[i] = a;
      n    = a + b;
      a    = b;
      b    = n;
    end
    return t;
  endfunction

  localparam wtab_t WT = f_wtab();

  // Partial-sum groups: bits of groups 11-9, 8-6, 5-3, 2-1.
  localparam int GRP_LO [NP] = '{24, 15, 6, 0};
  localparam int GRP_HI [NP] = '{32, 23, 14, 5};

  logic [NW-1:0] r_prev;
  logic          r_prev_ok;
  logic [2:0]    r_vld_pipe;   // [0]=S1, [1]=S2, [2]=S3
  logic [NW-1:0] r_s1_code;
  logic          r_xt_s1, r_xt_s2;
  logic [SW-1:0] r_psum [NP];

  logic [NW-1:0] w_rise, w_fall;
  logic          w_xt;
  logic [SW-1:0] w_psum [NP];
  logic [SW-1:0] w_sum;

  // A 3C violation is one wire of an adjacent pair rising while the other falls.
  assign w_rise = codein & ~r_prev;
  assign w_fall = ~codein & r_prev;
  assign w_xt   = r_prev_ok &
                  (|((w_rise[NW-2:0] & w_fall[NW-1:1]) |
                     (w_fall[NW-2:0] & w_rise[NW-1:1])));

  always_comb begin
    w_psum = '{default: '0};
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < NW; i++) begin
        if (i >= GRP_LO[p] && i <= GRP_HI[p] && r_s1_code[i])
          w_psum[p] = w_psum[p] + WT[i];
      end
    end
  end

  assign w_sum      = r_psum[0] + r_psum[1] + r_psum[2] + r_psum[3];
  assign data_valid = r_vld_pipe[2];

  // S1: capture word, evaluate 3C against the last accepted word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s1_code  <= '0;
      r_xt_s1    <= 1'b0;
      r_prev     <= '0;
      r_prev_ok  <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], code_valid};
      r_xt_s1    <= code_valid & w_xt;
      if (code_valid) begin
        r_s1_code <= codein;
        r_prev    <= codein;
        r_prev_ok <= 1'b1;
      end
    end
  end

  // S2: partial sums
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_psum  <= '{default: '0};
      r_xt_s2 <= 1'b0;
    end else begin
      r_xt_s2 <= r_xt_s1;
      if (r_vld_pipe[0]) r_psum <= w_psum;
    end
  end

  // S3: final sum and flags; everything holds across bubbles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataout   <= '0;
      range_err <= 1'b0;
      xt_err    <= 1'b0;
    end else if (r_vld_pipe[1]) begin
      dataout   <= w_sum[DLEN-1:0];
      range_err <= |w_sum[SW-1:DLEN];
      xt_err    <= r_xt_s2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err_count <= '0;
    else if (clr_count)
      err_count <= '0;
    else if (data_valid && (range_err || xt_err) && !(&err_count))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_tns_decoder_33.sv
module tb_tns_decoder_33;
  localparam int DLEN  = 23;
  localparam int CNT_W = 4;
  localparam int NW    = 33;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 1;
  localparam longint unsigned DMASK = (64'd1 << DLEN) - 1;

  logic             clock = 1'b0;
  logic             reset, code_valid, clr_count;
  logic [32:0]      codein;
  logic             data_valid, range_err, xt_err;
  logic [DLEN-1:0]  dataout;
  logic [CNT_W-1:0] err_count;

  always #5 clock = ~clock;

  tns_decoder_33 #(.DLEN(DLEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .code_valid(code_valid), .codein(codein),
    .clr_count(clr_count), .data_valid(data_valid), .dataout(dataout),
    .range_err(range_err), .xt_err(xt_err), .err_count(err_count)
  );

  int n_tests = 0, n_fail = 0;
  longint unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Code tables derived from counting the 3C-free codebook: W = bit weight,
  // Z = smallest value whose codeword has that bit set (encoder threshold).
  longint unsigned W [NW];
  longint unsigned Z [NW];

  typedef struct {
    longint unsigned cyc;
    longint unsigned data;
    bit              rerr;
    bit              xt;
  } exp_t;
  exp_t            q [$];
  logic [32:0]     m_prev;
  bit              m_prev_ok;
  longint unsigned exp_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic build_tables();
    longint unsigned n, o, zp, np, op;
    W[0] = 1; Z[0] = 1; n = 2; o = 1;
    for (int k = 1; k < NW; k++) begin
      zp = Z[k-1]; np = n; op = o;
      if (((k - 1) % 2) == 0) begin   // pair forbids bit k=0 over bit k-1=1
        W[k] = zp; Z[k] = zp; o = np;
      end else begin                  // pair forbids bit k=1 over bit k-1=0
        W[k] = op; Z[k] = np; o = op;
      end
      n = Z[k] + o;
    end
  endtask

  function automatic longint unsigned dec(input logic [32:0] c);
    longint unsigned s = 0;
    for (int i = 0; i < NW; i++) if (c[i]) s += W[i];
    return s;
  endfunction

  function automatic logic [32:0] enc(input longint unsigned v0);
    longint unsigned v = v0;
    logic [32:0] c = '0;
    for (int k = NW - 1; k >= 0; k--)
      if (v >= Z[k]) begin c[k] = 1'b1; v -= W[k]; end
    return c;
  endfunction

  function automatic bit xt_model(input logic [32:0] p, input logic [32:0] c);
    for (int i = 0; i < NW - 1; i++)
      if (p[i] != c[i] && p[i+1] != c[i+1] && c[i] != c[i+1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send(input logic [32:0] cw, input bit rt, input longint unsigned orig);
    exp_t e;
    longint unsigned s;
    s      = dec(cw);
    e.cyc  = cyc;
    e.data = rt ? orig : (s & DMASK);
    e.rerr = (s > DMASK);
    e.xt   = m_prev_ok && xt_model(m_prev, cw);
    q.push_back(e);
    m_prev = cw; m_prev_ok = 1'b1;
    code_valid = 1'b1; codein = cw;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      code_valid = 1'b0;
      codein     = {1'b0, 32'($urandom)};
      @(posedge clock); #1;
    end
  endtask

  // Scoreboard: each word must come out exactly 3 cycles after it was driven.
  always @(negedge clock) begin
    exp_t e;
    bit   edv;
    edv = 1'b0;
    if (q.size() > 0 && q[0].cyc + 3 == cyc) begin
      edv = 1'b1;
      e   = q.pop_front();
    end
    chk("data_valid", data_valid, edv);
    if (edv) begin
      chk("dataout", dataout, e.data);
      chk("range_err", range_err, e.rerr);
      chk("xt_err", xt_err, e.xt);
    end
    chk("err_count", err_count, exp_cnt);
    if (reset || clr_count) exp_cnt = 0;
    else if (edv && (e.rerr || e.xt) && exp_cnt < CMAX) exp_cnt++;
  end

  initial begin
    logic [32:0]     ones;
    longint unsigned v;
    ones = '1;
    reset = 1'b1; code_valid = 1'b0; codein = '0; clr_count = 1'b0;
    m_prev = '0; m_prev_ok = 1'b0; exp_cnt = 0;
    build_tables();

    #12;
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_dout", dataout, '0);
    chk("rst_rerr", range_err, 1'b0);
    chk("rst_xt", xt_err, 1'b0);
    chk("rst_cnt", err_count, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    send(33'h0, 0, 0);               idle(3);
    send(33'h1, 0, 0);               idle(1);
    send(33'h1_0000_0000, 0, 0);     idle(4);

    // bit0 falls while bit1 rises -> flagged; then 3 is clean
    send(33'h1, 0, 0);
    send(33'h2, 0, 0);
    send(33'h3, 0, 0);               idle(4);
    chk("xt_count", err_count, 1);

    send(33'h1_FFFF_FFFF, 0, 0);     idle(4);

    for (int i = 0; i < 1000; i++) begin
      v = longint'($urandom) & DMASK;
      send(enc(v), 1, v);
    end
    for (int i = 0; i < 1000; i++) begin
      v = longint'($urandom) & DMASK;
      send(enc(v), 1, v);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    // reset with two words in flight; next word would violate against them
    send(33'h1, 0, 0);
    send(33'h1, 0, 0);
    reset = 1'b1; code_valid = 1'b0;
    q.delete(); m_prev_ok = 1'b0; exp_cnt = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    send(33'h2, 0, 0);               idle(4);

    for (int i = 0; i < 20; i++) send(ones, 0, 0);
    idle(4);
    chk("sat_count", err_count, CMAX);

    send(ones, 0, 0);                idle(2);
    clr_count = 1'b1;                idle(1);
    clr_count = 1'b0;                idle(2);
    chk("clr_count", err_count, 0);

    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tns_decoder_33.md
Name: tns_decoder_33

Overview:
- Receive-side counterpart of the 33-wire TNS crosstalk-avoidance encoder.
- Accepts one 33-bit TNS codeword per cycle and reconstructs the `BLEN11-bit data word by weighted summation of the code bits.
- Also runs two link-integrity monitors:
  - range check on the decoded value;
  - 3C transition check against the previously accepted codeword.
- Sits at the bus receiver, directly after the wire-capture flops.

Parameters:
- DLEN, `BLEN11: decoded data width (from TNS.vh).
- CNT_W, 16: width of the saturating error counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- code_valid  in  1  codein is valid this cycle
- codein  in  33  received TNS codeword
- clr_count  in  1  synchronous clear of err_count
- data_valid  out  1  dataout/range_err/xt_err valid
- dataout  out  DLEN  decoded data word
- range_err  out  1  decoded sum >= 2^DLEN
- xt_err  out  1  3C violation versus previous accepted codeword
- err_count  out  CNT_W  saturating count of words flagged with any error

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: every output register is 0, all pipeline valid bits are 0, and the prev-codeword holder is cleared with prev_ok=0.
- Bit weights, group g = 1..11:
  - codein[3g-1] has weight TNS<g>_A.
  - codein[3g-2] has weight TNS<g>_B.
  - codein[3g-3] has weight TNS<g>_C.
  - Exception: codein[0] has weight 1.
- Internal sum width is DLEN+2, unsigned. No wrap is allowed before the final compare.
- Pipeline, fixed latency 3 cycles from code_valid sample to data_valid, no backpressure, throughput 1 word/cycle:
  - S1: register codein and code_valid. Compute the XT flag against prev.
  - S2: form 4 registered partial sums: groups 11-9, 8-6, 5-3, 2-1.
  - S3: register final sum. dataout = sum[DLEN-1:0]; range_err = (sum >> DLEN) != 0.
- Bubbles: when code_valid=0, a bubble propagates. data_valid=0 in that slot and dataout holds its last value.
- XT check, evaluated in S1 only when code_valid=1:
  - A violation is any adjacent pair i, i+1 (i = 0..31) where one bit rises 0->1 and the other falls 1->0 between prev and current.
  - xt_err is forced 0 when prev_ok=0.
  - After each accepted word: prev <= codein and prev_ok <= 1.
  - Idle cycles do not update prev.
- xt_err travels with its word and appears aligned with data_valid.
- err_count:
  - Increments by 1 on each data_valid cycle with (range_err | xt_err).
  - Saturates at 2^CNT_W-1.
- clr_count:
  - Sets err_count to 0 next cycle.
  - If an error word arrives in the same cycle, clear wins and the count becomes 0.
- Reset mid-operation:
  - All in-flight words are discarded and no data_valid pulse is produced for them.
  - The first word after reset never flags xt_err.

Test Plan:
- Reset, then code_valid=1 with codein=0 -> 3 cycles later data_valid=1, dataout=0, range_err=0, xt_err=0.
- codein=33'h1, then idle, then codein=33'h1_0000_0000 -> dataout=1, then dataout=TNS11_A; each word's data_valid arrives exactly 3 cycles after its input.
- Round trip:
  - Drive 2000 random DLEN-bit values through TNS_encoder_33 into the decoder, with code_valid asserted every cycle and then with random gaps.
  - Required: dataout equals the original data; range_err=0 and xt_err=0 on every word.
- XT violation: accept 33'h1, then 33'h2 (bit0 falls, bit1 rises) -> second word xt_err=1 and err_count increments to 1. Then 33'h3 -> xt_err=0.
- Range: codein=33'h1_FFFF_FFFF (all ones) -> range_err=1 if the weight sum is >= 2^DLEN, otherwise 0, per a reference model. err_count follows the flag.
- Counter and reset:
  - Force err_count to saturation via CNT_W=4 with 20 error words -> err_count holds at 15.
  - clr_count asserted coincident with an error word -> err_count becomes 0.
  - Assert reset with 2 words in flight -> no data_valid pulses, and the next accepted word has xt_err=0.
